// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared image geometry constants and gray server state enum
package lbp_pkg;

    localparam int IMG_W   = 128;
    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int IMG_PIX = IMG_W * IMG_W;
    localparam int CNT_W   = 18;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DRAIN = 2'd3
    } srv_state_e;

endpackage

// File: rtl/gray_mem.sv
// rtl/gray_mem.sv - image store, synchronous write port and zero-latency read port
module gray_mem #(
    parameter int DEPTH  = lbp_pkg::IMG_PIX,
    parameter int ADDR_W = lbp_pkg::ADDR_W,
    parameter int DATA_W = lbp_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write one pixel per accepted loader beat; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gray_img_server.sv
// rtl/gray_img_server.sv - gray image responder; GRAY_REQ_CNT_EN adds the req_cnt served-read counter
module gray_img_server
    import lbp_pkg::*;
#(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W,
    parameter int DATA_W = lbp_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [DATA_W-1:0] gray_data,
    input  logic              finish,
    output logic              req_err
`ifdef GRAY_REQ_CNT_EN
    ,
    output logic [CNT_W-1:0]  req_cnt
`endif
);

    localparam int PIX = IMG_W * IMG_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);

    srv_state_e        state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic              req_err_q;
    logic              accept;
    logic              serving;
    logic [DATA_W-1:0] mem_rdata;

    // Loader is only stalled outside EMPTY/LOAD and while reset is held.
    assign load_ready = !reset && (state_q == EMPTY || state_q == LOAD);
    assign accept     = load_valid && load_ready;
    assign serving    = (state_q == SERVE);
    assign gray_ready = serving;
    assign req_err    = req_err_q;
    assign gray_data  = (gray_req && serving) ? mem_rdata : '0;

    gray_mem #(
        .DEPTH  (PIX),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (load_data),
        .raddr_i (gray_addr),
        .rdata_o (mem_rdata)
    );

    // Image lifecycle FSM with write pointer and sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            req_err_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_q <= LOAD;
                LOAD:  if (accept && wr_ptr_q == LAST_ADDR) state_q <= SERVE;
                SERVE: if (finish) state_q <= DRAIN;
                DRAIN: state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            // The full address space is exactly one image, so the last beat wraps to 0.
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (gray_req && !serving) begin
                req_err_q <= 1'b1;
            end
        end
    end

`ifdef GRAY_REQ_CNT_EN
    logic [CNT_W-1:0] req_cnt_q;

    // Saturating count of served reads; restarts when a new image begins loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_cnt_q <= '0;
        end else if (state_q == EMPTY && accept) begin
            req_cnt_q <= '0;
        end else if (serving && gray_req && req_cnt_q != {CNT_W{1'b1}}) begin
            req_cnt_q <= req_cnt_q + 1'b1;
        end
    end

    assign req_cnt = req_cnt_q;
`endif

endmodule

// File: tb/tb_gray_img_server.sv
// tb/tb_gray_img_server.sv - randomized self-checking bench for gray_img_server
module tb_gray_img_server;

    localparam int PIX = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        finish;
    logic        req_err;
`ifdef GRAY_REQ_CNT_EN
    logic [17:0] req_cnt;
`endif

    int passed = 0;
    int total  = 0;

    logic [7:0] model_mem [PIX];
    int         model_reads;

    always #5 clk = ~clk;

    gray_img_server dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .finish     (finish),
        .req_err    (req_err)
`ifdef GRAY_REQ_CNT_EN
        ,
        .req_cnt    (req_cnt)
`endif
    );

    function automatic logic [7:0] pattern(input int a);
        logic [13:0] av;
        av = a[13:0];
        return av[7:0] ^ av[13:6];
    endfunction

    // mode 0: address pattern, 1: random bytes, 2: constant 0x5A
    task automatic do_load(input int nbeats, input int mode, input int idle_pct);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        model_reads = 0;
        while (cnt < nbeats) begin
            @(negedge clk);
            cyc++;
            if (cyc > 60000) begin
                total++;
                $display("FAIL load_timeout beats=%0d required=%0d", cnt, nbeats);
                break;
            end
            load_valid = ($urandom_range(99) >= idle_pct);
            case (mode)
                0: load_data = pattern(cnt);
                1: load_data = 8'($urandom);
                default: load_data = 8'h5A;
            endcase
            #1;
            total++;
            if (load_ready !== 1'b1) $display("FAIL load_ready_during_load beat=%0d got=%b exp=1", cnt, load_ready);
            else passed++;
            total++;
            if (gray_ready !== 1'b0) $display("FAIL early_gray_ready beat=%0d got=%b exp=0", cnt, gray_ready);
            else passed++;
            if (load_valid) begin
                model_mem[cnt] = load_data;
                cnt++;
            end
        end
        if (nbeats == PIX) begin
            @(negedge clk);
            load_valid = 1'b1;
            #1;
            total++;
            if (load_ready !== 1'b0) $display("FAIL load_ready_after_image got=%b exp=0", load_ready);
            else passed++;
            total++;
            if (gray_ready !== 1'b1) $display("FAIL gray_ready_latency got=%b exp=1", gray_ready);
            else passed++;
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic read_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            gray_req  = 1'b1;
            gray_addr = 14'($urandom);
            #1;
            total++;
            if (gray_data !== model_mem[gray_addr])
                $display("FAIL rand_read addr=%h got=%h exp=%h", gray_addr, gray_data, model_mem[gray_addr]);
            else passed++;
            model_reads++;
        end
        @(negedge clk);
        gray_req = 1'b0;
    endtask

    task automatic read_at(input logic [13:0] a, input logic [7:0] exp);
        @(negedge clk);
        gray_req  = 1'b1;
        gray_addr = a;
        #1;
        total++;
        if (gray_data !== exp) $display("FAIL read_at addr=%h got=%h exp=%h", a, gray_data, exp);
        else passed++;
        model_reads++;
        @(negedge clk);
        gray_req = 1'b0;
    endtask

    task automatic finish_and_drain(input logic err_exp);
        logic [7:0] exp;
        @(negedge clk);
        gray_req  = 1'b1;
        finish    = 1'b1;
        gray_addr = 14'h3FFF;
        exp = model_mem[14'h3FFF];
        #1;
        total++;
        if (gray_data !== exp) $display("FAIL finish_cycle_read got=%h exp=%h", gray_data, exp);
        else passed++;
        model_reads++;
        @(negedge clk);
        gray_req = 1'b0;
        finish   = 1'b0;
        #1;
        total++;
        if (gray_ready !== 1'b0 || load_ready !== 1'b0)
            $display("FAIL drain_cycle gray_ready=%b load_ready=%b exp=0/0", gray_ready, load_ready);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (gray_ready !== 1'b0 || load_ready !== 1'b1)
            $display("FAIL empty_after_drain gray_ready=%b load_ready=%b exp=0/1", gray_ready, load_ready);
        else passed++;
        total++;
        if (req_err !== err_exp) $display("FAIL req_err_after_drain got=%b exp=%b", req_err, err_exp);
        else passed++;
`ifdef GRAY_REQ_CNT_EN
        total++;
        if (req_cnt !== 18'(model_reads)) $display("FAIL req_cnt got=%0d exp=%0d", req_cnt, model_reads);
        else passed++;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        gray_req = 1'b0;
        gray_addr = '0;
        finish = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (load_ready !== 1'b0) $display("FAIL reset_load_ready_held got=%b exp=0", load_ready);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b exp=1", load_ready);
        else passed++;
        total++;
        if (gray_ready !== 1'b0 || req_err !== 1'b0 || gray_data !== 8'h00)
            $display("FAIL reset_outputs gray_ready=%b req_err=%b gray_data=%h exp=0/0/00", gray_ready, req_err, gray_data);
        else passed++;
    endtask

    task automatic test_full_load;
        do_load(PIX, 0, 0);
        read_at(14'h0081, 8'h83);
        read_random(2000);
        finish_and_drain(1'b0);
    endtask

    task automatic test_req_err_and_gap_load;
        @(negedge clk);
        gray_req  = 1'b1;
        gray_addr = 14'h1234;
        #1;
        total++;
        if (gray_data !== 8'h00 || req_err !== 1'b0)
            $display("FAIL empty_read gray_data=%h req_err=%b exp=00/0", gray_data, req_err);
        else passed++;
        @(negedge clk);
        gray_req = 1'b0;
        #1;
        total++;
        if (req_err !== 1'b1) $display("FAIL req_err_set got=%b exp=1", req_err);
        else passed++;
        do_load(PIX, 1, 30);
        total++;
        if (req_err !== 1'b1) $display("FAIL req_err_sticky_load got=%b exp=1", req_err);
        else passed++;
        read_random(1500);
        read_at(14'h0000, model_mem[0]);
        finish_and_drain(1'b1);
    endtask

    task automatic test_reset_mid_load;
        do_load(5000, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (gray_ready !== 1'b0 || load_ready !== 1'b1 || req_err !== 1'b0)
            $display("FAIL midload_reset gray_ready=%b load_ready=%b req_err=%b exp=0/1/0", gray_ready, load_ready, req_err);
        else passed++;
`ifdef GRAY_REQ_CNT_EN
        total++;
        if (req_cnt !== 18'd0) $display("FAIL midload_reset_cnt got=%0d exp=0", req_cnt);
        else passed++;
`endif
        do_load(PIX, 2, 0);
        read_at(14'h0000, 8'h5A);
        read_at(14'h2AAA, 8'h5A);
        read_at(14'h3FFF, 8'h5A);
        finish_and_drain(1'b0);
    endtask

    initial begin
        test_reset;
        test_full_load;
        test_req_err_and_gap_load;
        test_reset_mid_load;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
